// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default constants for the SLC-3 fetch unit
//
// Purpose: FSM state encoding, internal bus source select and default
//          parameter values imported by fetch_unit and its register slice.
// Ports:   none (package).
package fetch_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH1 = 2'd1,
    FETCH2 = 2'd2,
    FETCH3 = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_PC   = 2'd1,
    BUS_MDR  = 2'd2
  } bus_sel_t;

endpackage

// File: rtl/fetch_unit_load_reg.sv
// rtl/fetch_unit_load_reg.sv - synchronous-reset register with load enable
//
// Purpose: one datapath register (PC, MAR, MDR or IR) of the fetch unit.
// Ports:
//   clk_i  in   clock, rising edge
//   rst_i  in   synchronous active-high reset, loads RST_VAL
//   ld_i   in   load enable
//   d_i    in   W  next value
//   q_o    out  W  register contents
module load_reg #(
  parameter int           W       = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] val_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      val_q <= RST_VAL;
    end else if (ld_i) begin
      val_q <= d_i;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - self-sequencing SLC-3 instruction fetch datapath
//
// Purpose: owns PC, MAR, MDR, IR and the gated internal bus, and runs the
//          MAR<-PC / MDR<-M[MAR] / IR<-MDR sequence with its own FSM and a
//          ready/timeout memory handshake. Optional fetch counter is built
//          when the macro FETCH_CNT_EN is defined.
// Ports:
//   CLK              in   clock, all state on rising edge
//   Reset            in   synchronous active-high reset (highest priority)
//   Run              in   enable fetching
//   Hold             in   stall after current IR load
//   Redirect         in   load PC from Redirect_Target this edge
//   Redirect_Target  in   DATA_W branch target
//   Mem_Data         in   DATA_W read data
//   Mem_Rdy          in   read data valid this cycle
//   Mem_OE           out  read request (FETCH2 only)
//   Mem_Addr         out  DATA_W, equals MAR
//   PC/MAR/MDR/IR    out  DATA_W register contents
//   DataBus          out  DATA_W internal bus value
//   Fetch_Done       out  one-cycle pulse after IR load
//   Timeout          out  sticky memory timeout flag
//   Fetch_Count      out  DATA_W saturating IR-load count (FETCH_CNT_EN only)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = DEF_TIMEOUT
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Run,
  input  logic              Hold,
  input  logic              Redirect,
  input  logic [DATA_W-1:0] Redirect_Target,
  input  logic [DATA_W-1:0] Mem_Data,
  input  logic              Mem_Rdy,
  output logic              Mem_OE,
  output logic [DATA_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] DataBus,
  output logic              Fetch_Done,
  output logic              Timeout
`ifdef FETCH_CNT_EN
  ,
  output logic [DATA_W-1:0] Fetch_Count
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t state_q, state_d;
  bus_sel_t     bus_sel;

  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              timeout_q, timeout_d;
  logic              done_q, done_d;
  logic              pc_inc, pc_ld, mar_ld, mdr_ld, ir_ld, mem_oe;
  logic [DATA_W-1:0] pc_q, mar_q, mdr_q, ir_q, bus, pc_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    bus_sel   = BUS_NONE;
    mem_oe    = 1'b0;
    mar_ld    = 1'b0;
    mdr_ld    = 1'b0;
    ir_ld     = 1'b0;
    pc_inc    = 1'b0;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Run && !timeout_q) state_d = FETCH1;
      end
      FETCH1: begin
        bus_sel = BUS_PC;
        mar_ld  = 1'b1;
        pc_inc  = 1'b1;
        cnt_d   = '0;
        state_d = FETCH2;
      end
      FETCH2: begin
        mem_oe = 1'b1;
        if (Mem_Rdy) begin
          mdr_ld  = 1'b1;
          state_d = FETCH3;
        end else begin
          cnt_d = cnt_inc;
          // Give up once TIMEOUT FETCH2 cycles have passed without data.
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      FETCH3: begin
        bus_sel = BUS_MDR;
        ir_ld   = 1'b1;
        done_d  = 1'b1;
        state_d = (Run && !Hold) ? FETCH1 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    bus = '0;
    unique case (bus_sel)
      BUS_PC:  bus = pc_q;
      BUS_MDR: bus = mdr_q;
      default: bus = '0;
    endcase
  end

  // A redirect wins over the FETCH1 increment; MAR still takes the old PC
  // from the bus, so the in-flight fetch is unaffected.
  assign pc_ld = Redirect | pc_inc;
  assign pc_d  = Redirect ? Redirect_Target : (pc_q + DATA_W'(1));

  load_reg #(.W(DATA_W), .RST_VAL(RESET_PC)) u_pc (
    .clk_i(CLK), .rst_i(Reset), .ld_i(pc_ld), .d_i(pc_d), .q_o(pc_q)
  );

  load_reg #(.W(DATA_W), .RST_VAL('0)) u_mar (
    .clk_i(CLK), .rst_i(Reset), .ld_i(mar_ld), .d_i(bus), .q_o(mar_q)
  );

  load_reg #(.W(DATA_W), .RST_VAL('0)) u_mdr (
    .clk_i(CLK), .rst_i(Reset), .ld_i(mdr_ld), .d_i(Mem_Data), .q_o(mdr_q)
  );

  load_reg #(.W(DATA_W), .RST_VAL('0)) u_ir (
    .clk_i(CLK), .rst_i(Reset), .ld_i(ir_ld), .d_i(bus), .q_o(ir_q)
  );

`ifdef FETCH_CNT_EN
  logic [DATA_W-1:0] fcnt_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      fcnt_q <= '0;
    end else if (ir_ld && (fcnt_q != {DATA_W{1'b1}})) begin
      fcnt_q <= fcnt_q + DATA_W'(1);
    end
  end

  assign Fetch_Count = fcnt_q;
`endif

  assign Mem_OE     = mem_oe;
  assign Mem_Addr   = mar_q;
  assign PC         = pc_q;
  assign MAR        = mar_q;
  assign MDR        = mdr_q;
  assign IR         = ir_q;
  assign DataBus    = bus;
  assign Fetch_Done = done_q;
  assign Timeout    = timeout_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        CLK, Reset, Run, Hold, Redirect, Mem_Rdy, Mem_OE;
  logic [15:0] Redirect_Target, Mem_Data, Mem_Addr, PC, MAR, MDR, IR, DataBus;
  logic        Fetch_Done, Timeout;
`ifdef FETCH_CNT_EN
  logic [15:0] Fetch_Count;
`endif

  fetch_unit #(.DATA_W(16), .RESET_PC(16'h3000), .TIMEOUT(15)) dut (
    .CLK(CLK), .Reset(Reset), .Run(Run), .Hold(Hold), .Redirect(Redirect),
    .Redirect_Target(Redirect_Target), .Mem_Data(Mem_Data), .Mem_Rdy(Mem_Rdy),
    .Mem_OE(Mem_OE), .Mem_Addr(Mem_Addr), .PC(PC), .MAR(MAR), .MDR(MDR),
    .IR(IR), .DataBus(DataBus), .Fetch_Done(Fetch_Done), .Timeout(Timeout)
`ifdef FETCH_CNT_EN
    , .Fetch_Count(Fetch_Count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory image: 3000 holds 1234, everything else is addr ^ A5A5.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction
  assign Mem_Data = mem_word(Mem_Addr);

  // Mem_Rdy arrives after rdy_delay wait cycles in FETCH2.
  int rdy_delay;
  int oe_cnt;
  always @(posedge CLK) oe_cnt <= (Reset || !Mem_OE) ? 0 : oe_cnt + 1;
  assign Mem_Rdy = Mem_OE && (oe_cnt == rdy_delay);

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] mar;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every Fetch_Done pulse retires one expected fetch.
  always @(negedge CLK) begin
    if (!Reset && Fetch_Done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: Fetch_Done with IR=%0h, expected no fetch", IR);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_ir", {16'h0, IR}, {16'h0, e.ir});
        chk("sb_mar", {16'h0, MAR}, {16'h0, e.mar});
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!Fetch_Done && n < 40);
  endtask

  task automatic redirect_idle(input logic [15:0] t);
    Redirect = 1'b1;
    Redirect_Target = t;
    @(negedge CLK);
    Redirect = 1'b0;
  endtask

  int n, oe;

  initial begin
    Reset = 1'b1; Run = 1'b0; Hold = 1'b0; Redirect = 1'b0;
    Redirect_Target = 16'h0; rdy_delay = 0;
    repeat (2) @(negedge CLK);
    chk("rst_pc", {16'h0, PC}, 32'h3000);
    chk("rst_mar", {16'h0, MAR}, 32'h0);
    chk("rst_mdr", {16'h0, MDR}, 32'h0);
    chk("rst_ir", {16'h0, IR}, 32'h0);
    chk("rst_flags", {29'h0, Fetch_Done, Timeout, Mem_OE}, 32'h0);
    chk("rst_bus", {16'h0, DataBus}, 32'h0);

    // Baseline fetch from RESET_PC with immediate Mem_Rdy.
    Reset = 1'b0; Run = 1'b1;
    exp_q.push_back('{ir: 16'h1234, mar: 16'h3000});
    @(negedge CLK);
    chk("f1_bus", {16'h0, DataBus}, 32'h3000);
    @(negedge CLK);
    chk("f2_mar", {16'h0, MAR}, 32'h3000);
    chk("f2_pc", {16'h0, PC}, 32'h3001);
    chk("f2_oe", {31'h0, Mem_OE}, 32'h1);
    @(negedge CLK);
    chk("f3_bus", {16'h0, DataBus}, 32'h1234);
    Run = 1'b0;
    @(negedge CLK);
    chk("base_done", {31'h0, Fetch_Done}, 32'h1);
    chk("base_ir", {16'h0, IR}, 32'h1234);
    @(negedge CLK);
    chk("done_pulse", {31'h0, Fetch_Done}, 32'h0);
    chk("idle_bus", {16'h0, DataBus}, 32'h0);

    // Mem_Rdy three cycles late; Run dropped mid-fetch.
    rdy_delay = 3;
    Run = 1'b1;
    exp_q.push_back('{ir: 16'h95A4, mar: 16'h3001});
    @(negedge CLK);
    Run = 1'b0;
    oe = 0; n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (Mem_OE) oe++;
    end while (!Fetch_Done && n < 40);
    chk("late_latency", n, 6);
    chk("late_oe_cycles", oe, 4);
    chk("late_timeout", {31'h0, Timeout}, 32'h0);
    rdy_delay = 0;

    // Redirect during FETCH1 at PC=3005, back-to-back into the target.
    redirect_idle(16'h3005);
    chk("redir_idle_pc", {16'h0, PC}, 32'h3005);
    Run = 1'b1;
    exp_q.push_back('{ir: 16'h95A0, mar: 16'h3005});
    exp_q.push_back('{ir: 16'hE5A5, mar: 16'h4000});
    @(negedge CLK);
    Redirect = 1'b1; Redirect_Target = 16'h4000;
    @(negedge CLK);
    Redirect = 1'b0;
    chk("redir_mar", {16'h0, MAR}, 32'h3005);
    chk("redir_pc", {16'h0, PC}, 32'h4000);
    wait_done(n);
    chk("redir_first_done", n, 2);
    Run = 1'b0;
    wait_done(n);
    chk("back_to_back", n, 3);
    chk("redir_pc_after", {16'h0, PC}, 32'h4001);

    // PC wrap FFFF -> 0000.
    redirect_idle(16'hFFFF);
    Run = 1'b1;
    exp_q.push_back('{ir: 16'h5A5A, mar: 16'hFFFF});
    @(negedge CLK);
    Run = 1'b0;
    @(negedge CLK);
    chk("wrap_pc", {16'h0, PC}, 32'h0000);
    chk("wrap_mar", {16'h0, MAR}, 32'hFFFF);
    wait_done(n);
    chk("wrap_done", n, 2);

    // Hold in FETCH3 parks the FSM in IDLE even with Run high.
    Run = 1'b1; Hold = 1'b1;
    exp_q.push_back('{ir: 16'hA5A5, mar: 16'h0000});
    wait_done(n);
    chk("hold_latency", n, 4);
    chk("hold_idle_bus", {16'h0, DataBus}, 32'h0);
    chk("hold_idle_oe", {31'h0, Mem_OE}, 32'h0);
    Run = 1'b0; Hold = 1'b0;
    repeat (2) @(negedge CLK);
    chk("hold_ir", {16'h0, IR}, 32'hA5A5);

    // Memory never answers: timeout after 15 FETCH2 cycles.
    rdy_delay = 1000;
    Run = 1'b1;
    oe = 0; n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (Mem_OE) oe++;
    end while (!Timeout && n < 40);
    chk("to_flag", {31'h0, Timeout}, 32'h1);
    chk("to_oe_cycles", oe, 15);
    chk("to_ir", {16'h0, IR}, 32'hA5A5);
    chk("to_mdr", {16'h0, MDR}, 32'hA5A5);
    chk("to_idle_oe", {31'h0, Mem_OE}, 32'h0);
    oe = 0;
    repeat (5) begin
      @(negedge CLK);
      if (Mem_OE || DataBus != 16'h0) oe++;
    end
    chk("to_blocked", oe, 0);
    redirect_idle(16'h1234);
    chk("to_redirect_pc", {16'h0, PC}, 32'h1234);
    chk("to_sticky", {31'h0, Timeout}, 32'h1);

    // Reset clears the flag; then reset again while in FETCH2.
    Reset = 1'b1; Run = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    chk("clr_timeout", {31'h0, Timeout}, 32'h0);
    chk("clr_pc", {16'h0, PC}, 32'h3000);
    Run = 1'b1;
    repeat (2) @(negedge CLK);
    chk("mid_oe", {31'h0, Mem_OE}, 32'h1);
    chk("mid_pc", {16'h0, PC}, 32'h3001);
    Reset = 1'b1; Run = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    chk("mid_rst_pc", {16'h0, PC}, 32'h3000);
    chk("mid_rst_mar", {16'h0, MAR}, 32'h0);
    chk("mid_rst_mdr", {16'h0, MDR}, 32'h0);
    chk("mid_rst_ir", {16'h0, IR}, 32'h0);
    chk("mid_rst_oe", {31'h0, Mem_OE}, 32'h0);
    repeat (3) @(negedge CLK);
    chk("mid_rst_stays_idle", {31'h0, Mem_OE}, 32'h0);

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
